mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous modulo-N up/down counter for the DSD counter family. It supersedes the fixed 4-bit T-flip-flop ripple down counter with a single-clock design that adds:
- configurable width and modulus,
- a direction input,
- synchronous clear and parallel load,
- terminal-count and wrap flags,
- an optional one-shot mode.

The counting-enable input keeps the T-style semantics: deasserting it pauses the count without losing the value. It sits under lab top-levels as a timer, divider or event counter.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2^WIDTH.
- ONE_SHOT, 0, 0 = free-running wrap, 1 = stop at terminal value.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; 0 pauses and holds q (T-input semantics).
- up_dn  in  1  direction: 1 = up, 0 = down.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded when load=1.
- q  out  WIDTH  current count.
- tc  out  1  terminal count (combinational).
- wrap  out  1  one-cycle registered pulse on wrap-around.
- done  out  1  one-shot finished (ONE_SHOT=1 only; tied 0 otherwise).

## Operation
Per-edge priority, highest first:
1. rst.
2. clr.
3. load.
4. Count, when en=1.
5. Otherwise hold.

Reset:
- rst=1 forces q=0, wrap=0, done=0 and state RUN immediately, independent of clk.
- Release is seen on the next rising edge.

Clear:
- clr=1 sets q=0, wrap=0, done=0 and state RUN.

Load:
- load=1 sets q=load_val and state RUN; done clears.
- If load_val ≥ MODULUS, q is clamped to MODULUS-1.
- wrap=0 on a load edge.

Count:
- Up: q+1, with MODULUS-1 → 0.
- Down: q-1, with 0 → MODULUS-1.
- Arithmetic uses WIDTH+1 bits internally, so no aliasing occurs when MODULUS = 2^WIDTH.

Terminal count:
- tc = en & (up_dn ? q==MODULUS-1 : q==0).
- tc follows direction changes in the same cycle.

Wrap:
- wrap is registered.
- It is 1 for exactly the cycle after the edge on which q wrapped; otherwise 0.

State machine (ONE_SHOT=1):
- States: RUN, DONE.
- RUN → DONE on a count edge where tc=1. On that edge q does not wrap; it stays at the terminal value (MODULUS-1 up, 0 down), and wrap stays 0.
- DONE holds q regardless of en or up_dn, with done=1.
- DONE → RUN only on clr, load or rst.

State machine (ONE_SHOT=0):
- The FSM stays in RUN.

Other rules:
- Changing up_dn while en=1 takes effect on the next edge; no lost or double steps.

## Timing
- All state (q, wrap, done, FSM) is updated on the rising clk edge, except the asynchronous rst.
- q latency: 1 cycle from en/clr/load to the new q.
- tc: combinational, same cycle as q/en/up_dn.
- wrap: valid in the cycle following the wrapping edge, 1 cycle wide.
- done: rises in the cycle after the terminal edge.
- Simultaneous clr+load: clr wins.
- Simultaneous load+en: load wins and no count step occurs.
- rst asserted mid-cycle: q=0 within the same cycle; no partial update on the following edge while rst=1.
- Back-to-back wraps (MODULUS=2, en=1) pulse wrap every other cycle.

## Structure
- Shared package dsd_counter_pkg holds:
  - the state typedef (ST_RUN, ST_DONE),
  - direction constants (DIR_UP=1, DIR_DN=0),
  - the function for terminal value given direction and modulus.
- Sub-module mod_count_core holds the next-value datapath. It is pure combinational and computes from q, up_dn and MODULUS:
  - next count,
  - the wrap condition,
  - clamped load value.
- The top level owns the registers, priority logic and FSM.
- Parameter legality is checked at elaboration; an illegal MODULUS is a fatal error.

## Test plan
Parameters WIDTH=4, MODULUS=10 unless stated.
- Up count from reset release, en=1, up_dn=1 → q=0,1,…,9,0; tc=1 while q=9; wrap=1 only in the cycle q=0 after 9.
- Down count: rst release, up_dn=0, en=1 → q=0,9,8,7; tc=1 at q=0 before the first edge; wrap=1 in the cycle q=9.
- Pause: drop en at q=5 for 3 cycles → q holds 5, tc=0; restore en → q=6 next edge.
- Load: load_val=7 → q=7; load_val=12 → q=9 (clamped); load and en together at q=3, load_val=2 → q=2.
- One-shot (ONE_SHOT=1): up count reaches 9 → done=1 next cycle, q stays 9 with en=1; clr → q=0, done=0, counting resumes.
- Async reset mid-count: assert rst between edges at q=6 → q=0 before the next edge; hold rst across 2 edges → q stays 0; release → counting restarts from 0. MODULUS=16 run: q wraps 15 → 0 correctly.

Source files
------------

// File: rtl/dsd_counter_pkg.sv
// Shared types, constants and helpers for the DSD counter family.
package dsd_counter_pkg;

  // One-shot sequencing states.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Direction encoding of up_dn.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Terminal value for a given direction: top of range going up, zero going down.
  function automatic int unsigned term_value(input logic dir, input int unsigned modulus);
    return (dir == DIR_UP) ? (modulus - 1) : 0;
  endfunction

  // Width 1..16, modulus 2..2^width, one-shot flag 0 or 1.
  function automatic logic params_legal(input int unsigned width,
                                        input int unsigned modulus,
                                        input int unsigned one_shot);
    logic ok;
    ok = 1'b1;
    if (width < 1 || width > 16)                 ok = 1'b0;
    else if (modulus < 2 || modulus > (1 << width)) ok = 1'b0;
    if (one_shot > 1)                            ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mod_count_core.sv
// Combinational next-value datapath: step, wrap detection, terminal detect, load clamp.
module mod_count_core
  import dsd_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up_dn,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_wrap,
  output logic             o_at_term,
  output logic [WIDTH-1:0] o_load_clamp
);

  // One extra bit so MODULUS = 2^WIDTH is representable and borrows are visible.
  localparam int unsigned      CW      = WIDTH + 1;
  localparam logic [CW-1:0]    MOD_EXT = CW'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic [CW-1:0]    w_q_ext;
  logic [CW-1:0]    w_inc;
  logic [CW-1:0]    w_dec;
  logic [CW-1:0]    w_lv_ext;
  logic [WIDTH-1:0] w_term;

  // Step in the selected direction, folding back at the range edges.
  always_comb begin
    o_next_q = i_q;
    o_wrap   = 1'b0;
    w_q_ext  = {1'b0, i_q};
    w_inc    = w_q_ext + CW'(1);
    w_dec    = w_q_ext - CW'(1);
    if (i_up_dn == DIR_UP) begin
      o_wrap   = (w_inc >= MOD_EXT);
      o_next_q = o_wrap ? '0 : w_inc[WIDTH-1:0];
    end else begin
      o_wrap   = w_dec[CW-1];
      o_next_q = o_wrap ? MAX_Q : w_dec[WIDTH-1:0];
    end
  end

  // Terminal-value compare for the current direction.
  always_comb begin
    w_term    = WIDTH'(term_value(i_up_dn, MODULUS));
    o_at_term = (i_q == w_term);
  end

  // Out-of-range load values saturate to the top of the range.
  always_comb begin
    w_lv_ext     = {1'b0, i_load_val};
    o_load_clamp = (w_lv_ext >= MOD_EXT) ? MAX_Q : i_load_val;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clear, load, wrap pulse and optional one-shot stop.
module mod_updown_counter
  import dsd_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned ONE_SHOT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_done
);

  // Reject illegal parameter sets at elaboration.
  if (!params_legal(WIDTH, MODULUS, ONE_SHOT)) begin : g_param_check
    $fatal(1, "mod_updown_counter: illegal WIDTH/MODULUS/ONE_SHOT");
  end

  localparam logic ONE_SHOT_EN = (ONE_SHOT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic [WIDTH-1:0] w_step_q;
  logic             w_step_wrap;
  logic             w_at_term;
  logic [WIDTH-1:0] w_load_clamp;
  logic             w_tc;

  mod_count_core #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_core (
    .i_q          (r_q),
    .i_up_dn      (i_up_dn),
    .i_load_val   (i_load_val),
    .o_next_q     (w_step_q),
    .o_wrap       (w_step_wrap),
    .o_at_term    (w_at_term),
    .o_load_clamp (w_load_clamp)
  );

  assign w_tc = i_en & w_at_term;

  // State and datapath registers; reset is asynchronous.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_q     <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Priority clr > load > count > hold; DONE freezes the count until clr/load.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_wrap_nxt  = 1'b0;
    if (i_clr) begin
      w_state_nxt = ST_RUN;
      w_q_nxt     = '0;
    end else if (i_load) begin
      w_state_nxt = ST_RUN;
      w_q_nxt     = w_load_clamp;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_en) begin
            if (ONE_SHOT_EN && w_tc) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_q_nxt    = w_step_q;
              w_wrap_nxt = w_step_wrap;
            end
          end
        end
        ST_DONE: begin
          w_q_nxt = r_q;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign o_q    = r_q;
  assign o_tc   = w_tc;
  assign o_wrap = r_wrap;
  assign o_done = r_done;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter.
`timescale 1ns/1ps
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q10, q_os, q16;
  logic       tc10, tc_os, tc16, tc2;
  logic       wrap10, wrap_os, wrap16, wrap2;
  logic       done10, done_os, done16, done2;
  logic [0:0] q2;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_clr(clr),
    .i_load(load), .i_load_val(load_val),
    .o_q(q10), .o_tc(tc10), .o_wrap(wrap10), .o_done(done10));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1)) u_os (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_clr(clr),
    .i_load(load), .i_load_val(load_val),
    .o_q(q_os), .o_tc(tc_os), .o_wrap(wrap_os), .o_done(done_os));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(0)) u_m16 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_clr(clr),
    .i_load(load), .i_load_val(load_val),
    .o_q(q16), .o_tc(tc16), .o_wrap(wrap16), .o_done(done16));

  mod_updown_counter #(.WIDTH(1), .MODULUS(2), .ONE_SHOT(0)) u_m2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_clr(clr),
    .i_load(load), .i_load_val(load_val[0:0]),
    .o_q(q2), .o_tc(tc2), .o_wrap(wrap2), .o_done(done2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (q10 !== 4'd0)  begin n_fail++; $display("FAIL reset_q: got %0d expected 0", q10); end
    n_checks++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %0b expected 0", wrap10); end
    n_checks++; if (done_os !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done_os); end
    n_checks++; if (tc10 !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %0b expected 0", tc10); end
    n_checks++; if (done10 !== 1'b0) begin n_fail++; $display("FAIL reset_done_free: got %0b expected 0", done10); end
  endtask

  task automatic test_up_count();
    logic [3:0] eq;
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      eq = 4'(i % 10);
      n_checks++; if (q10 !== eq) begin n_fail++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q10, eq); end
      n_checks++; if (tc10 !== (eq == 4'd9)) begin n_fail++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, tc10, (eq == 4'd9)); end
      n_checks++; if (wrap10 !== (i == 10)) begin n_fail++; $display("FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap10, (i == 10)); end
    end
  endtask

  task automatic test_down_count();
    do_reset();
    en = 1'b1; up_dn = 1'b0;
    #1;
    n_checks++; if (tc10 !== 1'b1) begin n_fail++; $display("FAIL dn_tc0: got %0b expected 1", tc10); end
    step();
    n_checks++; if (q10 !== 4'd9) begin n_fail++; $display("FAIL dn_q9: got %0d expected 9", q10); end
    n_checks++; if (wrap10 !== 1'b1) begin n_fail++; $display("FAIL dn_wrap9: got %0b expected 1", wrap10); end
    n_checks++; if (tc10 !== 1'b0) begin n_fail++; $display("FAIL dn_tc9: got %0b expected 0", tc10); end
    step();
    n_checks++; if (q10 !== 4'd8) begin n_fail++; $display("FAIL dn_q8: got %0d expected 8", q10); end
    n_checks++; if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL dn_wrap8: got %0b expected 0", wrap10); end
    step();
    n_checks++; if (q10 !== 4'd7) begin n_fail++; $display("FAIL dn_q7: got %0d expected 7", q10); end
  endtask

  task automatic test_pause();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    repeat (5) step();
    n_checks++; if (q10 !== 4'd5) begin n_fail++; $display("FAIL pause_pre: got %0d expected 5", q10); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (q10 !== 4'd5) begin n_fail++; $display("FAIL pause_hold[%0d]: got %0d expected 5", i, q10); end
      n_checks++; if (tc10 !== 1'b0) begin n_fail++; $display("FAIL pause_tc[%0d]: got %0b expected 0", i, tc10); end
    end
    en = 1'b1;
    step();
    n_checks++; if (q10 !== 4'd6) begin n_fail++; $display("FAIL pause_resume: got %0d expected 6", q10); end
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_val = 4'd7;
    step();
    n_checks++; if (q10 !== 4'd7) begin n_fail++; $display("FAIL load_7: got %0d expected 7", q10); end
    load_val = 4'd12;
    step();
    n_checks++; if (q10 !== 4'd9) begin n_fail++; $display("FAIL load_clamp: got %0d expected 9", q10); end
    n_checks++; if (q16 !== 4'd12) begin n_fail++; $display("FAIL load_m16: got %0d expected 12", q16); end
    load_val = 4'd3;
    step();
    n_checks++; if (q10 !== 4'd3) begin n_fail++; $display("FAIL load_3: got %0d expected 3", q10); end
    en = 1'b1; load_val = 4'd2;
    step();
    n_checks++; if (q10 !== 4'd2) begin n_fail++; $display("FAIL load_en: got %0d expected 2", q10); end
    load = 1'b0;
    step();
    n_checks++; if (q10 !== 4'd3) begin n_fail++; $display("FAIL load_then_count: got %0d expected 3", q10); end
    clr = 1'b1; load = 1'b1; load_val = 4'd5;
    step();
    n_checks++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL clr_over_load: got %0d expected 0", q10); end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_one_shot();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    repeat (9) step();
    n_checks++; if (q_os !== 4'd9) begin n_fail++; $display("FAIL os_q9: got %0d expected 9", q_os); end
    n_checks++; if (tc_os !== 1'b1) begin n_fail++; $display("FAIL os_tc: got %0b expected 1", tc_os); end
    n_checks++; if (done_os !== 1'b0) begin n_fail++; $display("FAIL os_done_early: got %0b expected 0", done_os); end
    step();
    n_checks++; if (q_os !== 4'd9) begin n_fail++; $display("FAIL os_stop: got %0d expected 9", q_os); end
    n_checks++; if (done_os !== 1'b1) begin n_fail++; $display("FAIL os_done: got %0b expected 1", done_os); end
    n_checks++; if (wrap_os !== 1'b0) begin n_fail++; $display("FAIL os_wrap: got %0b expected 0", wrap_os); end
    up_dn = 1'b0;
    step();
    n_checks++; if (q_os !== 4'd9) begin n_fail++; $display("FAIL os_hold_dir: got %0d expected 9", q_os); end
    n_checks++; if (done_os !== 1'b1) begin n_fail++; $display("FAIL os_done_hold: got %0b expected 1", done_os); end
    clr = 1'b1;
    step();
    clr = 1'b0; up_dn = 1'b1;
    n_checks++; if (q_os !== 4'd0) begin n_fail++; $display("FAIL os_clr_q: got %0d expected 0", q_os); end
    n_checks++; if (done_os !== 1'b0) begin n_fail++; $display("FAIL os_clr_done: got %0b expected 0", done_os); end
    step();
    n_checks++; if (q_os !== 4'd1) begin n_fail++; $display("FAIL os_resume: got %0d expected 1", q_os); end
    up_dn = 1'b0;
    step();
    n_checks++; if (q_os !== 4'd0) begin n_fail++; $display("FAIL os_dn_q0: got %0d expected 0", q_os); end
    step();
    n_checks++; if (q_os !== 4'd0) begin n_fail++; $display("FAIL os_dn_stop: got %0d expected 0", q_os); end
    n_checks++; if (done_os !== 1'b1) begin n_fail++; $display("FAIL os_dn_done: got %0b expected 1", done_os); end
    load = 1'b1; load_val = 4'd4;
    step();
    load = 1'b0;
    n_checks++; if (q_os !== 4'd4) begin n_fail++; $display("FAIL os_load_q: got %0d expected 4", q_os); end
    n_checks++; if (done_os !== 1'b0) begin n_fail++; $display("FAIL os_load_done: got %0b expected 0", done_os); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    repeat (6) step();
    n_checks++; if (q10 !== 4'd6) begin n_fail++; $display("FAIL ar_pre: got %0d expected 6", q10); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL ar_immediate: got %0d expected 0", q10); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (q10 !== 4'd0) begin n_fail++; $display("FAIL ar_hold[%0d]: got %0d expected 0", i, q10); end
    end
    rst = 1'b0;
    step();
    n_checks++; if (q10 !== 4'd1) begin n_fail++; $display("FAIL ar_restart: got %0d expected 1", q10); end
  endtask

  task automatic test_mod16();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    repeat (15) step();
    n_checks++; if (q16 !== 4'd15) begin n_fail++; $display("FAIL m16_q15: got %0d expected 15", q16); end
    n_checks++; if (tc16 !== 1'b1) begin n_fail++; $display("FAIL m16_tc: got %0b expected 1", tc16); end
    step();
    n_checks++; if (q16 !== 4'd0) begin n_fail++; $display("FAIL m16_wrap_q: got %0d expected 0", q16); end
    n_checks++; if (wrap16 !== 1'b1) begin n_fail++; $display("FAIL m16_wrap: got %0b expected 1", wrap16); end
    up_dn = 1'b0;
    step();
    n_checks++; if (q16 !== 4'd15) begin n_fail++; $display("FAIL m16_dn_q: got %0d expected 15", q16); end
    n_checks++; if (wrap16 !== 1'b1) begin n_fail++; $display("FAIL m16_dn_wrap: got %0b expected 1", wrap16); end
  endtask

  task automatic test_back_to_back();
    logic eq;
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      eq = ((i % 2) == 1);
      n_checks++; if (q2 !== eq) begin n_fail++; $display("FAIL b2b_q[%0d]: got %0d expected %0d", i, q2, eq); end
      n_checks++; if (wrap2 !== !eq) begin n_fail++; $display("FAIL b2b_wrap[%0d]: got %0b expected %0b", i, wrap2, !eq); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_up_count();
    test_down_count();
    test_pause();
    test_load();
    test_one_shot();
    test_async_reset();
    test_mod16();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
